count_seq_monitor: RTL and testbench
====================================

COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

Interface
REQ-001 Parameter LOCK_N, default 3: number of consecutive correct successor samples needed to enter LOCKED; legal range 1..7.
REQ-002 clk_1H  input  1  sample clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 seg_in4  input  3  count value from the 3-bit wrap counter producer; sampled only when enable=1.
REQ-005 enable  input  1  sample qualifier; 0 means hold all state.
REQ-006 locked  output  1  1 while the FSM is in LOCKED.
REQ-007 seq_err  output  1  one-cycle pulse on a successor violation while LOCKED.
REQ-008 err_cnt  output  4  count of seq_err pulses; saturates at 15.
REQ-009 lap_cnt  output  8  count of 7->0 wraps observed while LOCKED; wraps from 255 to 0.
REQ-010 seg7  output  7  active-low segments {a,b,c,d,e,f,g} (seg7[6]=a), showing the last accepted sample.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, TRACK and LOCKED.
REQ-012 Internal registers SHALL be prev (3 bits, last accepted sample) and good_cnt (3 bits).
REQ-013 "Correct successor" SHALL mean seg_in4 == (prev+1) mod 8, so 7->0 is correct; a repeated value or any skip is a mismatch.
REQ-014 IDLE with enable=1: capture seg_in4 into prev, clear good_cnt, go to TRACK; no comparison is made.
REQ-015 TRACK with enable=1 and a correct successor: increment good_cnt; when the incremented value equals LOCK_N, go to LOCKED in the same edge.
REQ-016 TRACK with enable=1 and a mismatch: clear good_cnt, stay in TRACK; no seq_err and no err_cnt change.
REQ-017 LOCKED with enable=1 and a correct successor: stay in LOCKED; if prev==7 and seg_in4==0, increment lap_cnt modulo 256.
REQ-018 LOCKED with enable=1 and a mismatch: assert seq_err for exactly one cycle, increment err_cnt unless it is 15, clear good_cnt, go to TRACK.
REQ-019 Every enabled sample in TRACK or LOCKED SHALL update prev to seg_in4, including mismatching samples.
REQ-020 enable=0: all registers hold, and seq_err SHALL be 0 on that cycle.
REQ-021 seq_err, locked, err_cnt, lap_cnt and seg7 SHALL be registered outputs, valid one clk_1H edge after the accepted sample (latency 1).
REQ-022 locked SHALL rise on the same edge as the FSM enters LOCKED and fall on the same edge as the mismatch.
REQ-023 lap_cnt SHALL be retained on loss of lock; only reset clears it.

Reset
REQ-024 When reset=1, the block SHALL asynchronously set state=IDLE, prev=0, good_cnt=0, locked=0, seq_err=0, err_cnt=0 and lap_cnt=0.
REQ-025 When reset=1, seg7 SHALL be 7'b0000001 (digit 0) with SEG_DECODE_EN defined, or 7'b1111111 without it.
REQ-026 Reset asserted mid-sequence SHALL discard lock; after release, the first enabled sample is treated as an IDLE capture.

Configuration
REQ-027 Macro SEG_DECODE_EN defined: seg7 SHALL be a registered hex decode of the accepted sample for digits 0-7 (0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111).
REQ-028 Macro SEG_DECODE_EN undefined: seg7 SHALL be constant 7'b1111111 (blank) and no decode logic SHALL be synthesized; all other behaviour is unchanged.

Verification
REQ-029 Reset, then enable=1 with seg_in4=5,6,7,0 -> locked=1 after the 4th edge; lap_cnt=1 only if the 7->0 transition occurs while locked (here lap_cnt=0).
REQ-030 Locked stream 0..7,0,1 -> lap_cnt increments by 1 on the 7->0 edge; seq_err stays 0 and err_cnt=0.
REQ-031 While locked, feed 3 then 5 -> seq_err is a single one-cycle pulse, err_cnt=1, locked=0, and relock requires 3 further correct successors.
REQ-032 While locked, repeat the value 4,4 -> mismatch: seq_err=1 and err_cnt increments; 17 forced errors -> err_cnt holds at 15.
REQ-033 While locked, enable=0 for 5 cycles with a changing seg_in4 -> no state change and seq_err=0; resuming with the correct successor keeps locked=1.
REQ-034 Assert reset asynchronously between edges with lap_cnt=9 -> all outputs go to their reset values immediately; with SEG_DECODE_EN, seg7=0000001.

Source files
------------

// File: rtl/count_seq_monitor.sv
// Successor monitor for a 3-bit wrap counter: locks after LOCK_N correct steps, flags breaks while locked.
// Optional 7-segment decode of the last accepted sample is built when SEG_DECODE_EN is defined.
module count_seq_monitor #(
  parameter int LOCK_N = 3
) (
  input  logic       clk_1H,
  input  logic       reset,
  input  logic [2:0] seg_in4,
  input  logic       enable,
  output logic       locked,
  output logic       seq_err,
  output logic [3:0] err_cnt,
  output logic [7:0] lap_cnt,
  output logic [6:0] seg7
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam logic [2:0] LOCK_W = 3'(LOCK_N);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_prev, w_prev_nxt;
  logic [2:0] r_good_cnt, w_good_nxt;
  logic       r_locked;
  logic       r_seq_err, w_seq_err_nxt;
  logic [3:0] r_err_cnt, w_err_nxt;
  logic [7:0] r_lap_cnt, w_lap_nxt;
  logic [2:0] w_succ, w_good_inc;
  logic       w_match, w_wrap;

  assign w_succ     = r_prev + 3'd1;
  assign w_match    = (seg_in4 == w_succ);
  assign w_good_inc = r_good_cnt + 3'd1;
  assign w_wrap     = (r_prev == 3'd7) && (seg_in4 == 3'd0);

  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prev     <= 3'd0;
      r_good_cnt <= 3'd0;
      r_locked   <= 1'b0;
      r_seq_err  <= 1'b0;
      r_err_cnt  <= 4'd0;
      r_lap_cnt  <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= w_prev_nxt;
      r_good_cnt <= w_good_nxt;
      r_locked   <= (w_state_nxt == LOCKED);
      r_seq_err  <= w_seq_err_nxt;
      r_err_cnt  <= w_err_nxt;
      r_lap_cnt  <= w_lap_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_prev_nxt    = r_prev;
    w_good_nxt    = r_good_cnt;
    w_seq_err_nxt = 1'b0;
    w_err_nxt     = r_err_cnt;
    w_lap_nxt     = r_lap_cnt;
    if (enable) begin
      // every accepted sample becomes the new reference, match or not
      w_prev_nxt = seg_in4;
      case (r_state)
        IDLE: begin
          w_good_nxt  = 3'd0;
          w_state_nxt = TRACK;
        end
        TRACK: begin
          if (w_match) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == LOCK_W) w_state_nxt = LOCKED;
          end else begin
            w_good_nxt = 3'd0;
          end
        end
        LOCKED: begin
          if (w_match) begin
            if (w_wrap) w_lap_nxt = r_lap_cnt + 8'd1;
          end else begin
            w_seq_err_nxt = 1'b1;
            if (r_err_cnt != 4'd15) w_err_nxt = r_err_cnt + 4'd1;
            w_good_nxt    = 3'd0;
            w_state_nxt   = TRACK;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign locked  = r_locked;
  assign seq_err = r_seq_err;
  assign err_cnt = r_err_cnt;
  assign lap_cnt = r_lap_cnt;

`ifdef SEG_DECODE_EN
  function automatic logic [6:0] seg_decode(input logic [2:0] d);
    case (d)
      3'd0:    seg_decode = 7'b0000001;
      3'd1:    seg_decode = 7'b1001111;
      3'd2:    seg_decode = 7'b0010010;
      3'd3:    seg_decode = 7'b0000110;
      3'd4:    seg_decode = 7'b1001100;
      3'd5:    seg_decode = 7'b0100100;
      3'd6:    seg_decode = 7'b0100000;
      default: seg_decode = 7'b0001111;
    endcase
  endfunction

  logic [6:0] r_seg7;

  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset)       r_seg7 <= 7'b0000001;
    else if (enable) r_seg7 <= seg_decode(seg_in4);
  end

  assign seg7 = r_seg7;
`else
  assign seg7 = 7'b1111111;
`endif

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: a reference model pushes expected outputs per sample, checked after each edge.
module tb_count_seq_monitor;

  localparam int LOCK_N = 3;

  logic       clk_1H = 1'b0;
  logic       reset;
  logic [2:0] seg_in4;
  logic       enable;
  logic       locked;
  logic       seq_err;
  logic [3:0] err_cnt;
  logic [7:0] lap_cnt;
  logic [6:0] seg7;

  count_seq_monitor #(.LOCK_N(LOCK_N)) dut (
    .clk_1H (clk_1H),
    .reset  (reset),
    .seg_in4(seg_in4),
    .enable (enable),
    .locked (locked),
    .seq_err(seq_err),
    .err_cnt(err_cnt),
    .lap_cnt(lap_cnt),
    .seg7   (seg7)
  );

  always #5 clk_1H = ~clk_1H;

  typedef struct packed {
    logic       locked;
    logic       serr;
    logic [3:0] err;
    logic [7:0] lap;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // reference model state: 0=IDLE 1=TRACK 2=LOCKED
  int         m_state;
  int         m_prev;
  int         m_good;
  int         m_err;
  int         m_lap;
  logic       m_serr;
  logic [6:0] m_seg;

  function automatic logic [6:0] seg_ref(input int d);
`ifdef SEG_DECODE_EN
    logic [6:0] tbl [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
    return tbl[d];
`else
    return 7'b1111111;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_good = 0; m_err = 0; m_lap = 0;
    m_serr  = 1'b0;
    m_seg   = seg_ref(0);
`ifndef SEG_DECODE_EN
    m_seg   = 7'b1111111;
`endif
  endtask

  task automatic model_step(input logic en, input int v);
    bit ok;
    m_serr = 1'b0;
    if (en) begin
      ok = (v == ((m_prev + 1) % 8));
      m_seg = seg_ref(v);
      if (m_state == 0) begin
        m_good = 0; m_state = 1;
      end else if (m_state == 1) begin
        if (ok) begin
          m_good++;
          if (m_good == LOCK_N) m_state = 2;
        end else m_good = 0;
      end else begin
        if (ok) begin
          if (m_prev == 7 && v == 0) m_lap = (m_lap + 1) % 256;
        end else begin
          m_serr = 1'b1;
          if (m_err < 15) m_err++;
          m_good = 0; m_state = 1;
        end
      end
      m_prev = v;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".locked"},  int'(locked),  int'(e.locked));
    chk({tag, ".seq_err"}, int'(seq_err), int'(e.serr));
    chk({tag, ".err_cnt"}, int'(err_cnt), int'(e.err));
    chk({tag, ".lap_cnt"}, int'(lap_cnt), int'(e.lap));
    chk({tag, ".seg7"},    int'(seg7),    int'(e.seg));
  endtask

  task automatic step(input string tag, input logic en, input int v);
    exp_t e;
    enable  = en;
    seg_in4 = 3'(v);
    model_step(en, v);
    e = '{locked: (m_state == 2), serr: m_serr, err: 4'(m_err), lap: 8'(m_lap), seg: m_seg};
    q.push_back(e);
    @(posedge clk_1H);
    #1;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL %s.queue: observed=empty expected=entry", tag);
    end
    if (q.size() > 0) check_outputs(tag, q.pop_front());
  endtask

  exp_t rst_exp;

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    seg_in4 = 3'd0;
    model_reset();
`ifdef SEG_DECODE_EN
    rst_exp = '{locked: 1'b0, serr: 1'b0, err: 4'd0, lap: 8'd0, seg: 7'b0000001};
`else
    rst_exp = '{locked: 1'b0, serr: 1'b0, err: 4'd0, lap: 8'd0, seg: 7'b1111111};
`endif
    #2;
    check_outputs("reset", rst_exp);
    #10 reset = 1'b0;

    // acquire lock: 5 is the capture, 6/7/0 are three correct successors
    step("acq5", 1'b1, 5);
    step("acq6", 1'b1, 6);
    step("acq7", 1'b1, 7);
    step("acq0", 1'b1, 0);
    chk("acq.locked_const", int'(locked), 1);
    chk("acq.lap_const", int'(lap_cnt), 0);

    // locked run through a wrap
    for (int i = 1; i <= 9; i++) step("run", 1'b1, i % 8);
    chk("run.lap_const", int'(lap_cnt), 1);
    chk("run.err_const", int'(err_cnt), 0);

    // skip to 3, then 5 while tracking, then relock with 6,7,0
    step("skip3", 1'b1, 3);
    chk("skip3.err_const", int'(err_cnt), 1);
    step("skip5", 1'b1, 5);
    chk("skip5.seqerr_const", int'(seq_err), 0);
    step("rel6", 1'b1, 6);
    step("rel7", 1'b1, 7);
    step("rel0", 1'b1, 0);
    chk("rel.locked_const", int'(locked), 1);

    // repeated value while locked, then drive error count into saturation
    step("r1", 1'b1, 1);
    step("r2", 1'b1, 2);
    step("r3", 1'b1, 3);
    step("r4", 1'b1, 4);
    step("r4dup", 1'b1, 4);
    chk("dup.seqerr_const", int'(seq_err), 1);
    chk("dup.err_const", int'(err_cnt), 2);
    for (int n = 0; n < 17; n++) begin
      for (int k = 0; k < LOCK_N; k++) step("sat_relock", 1'b1, (m_prev + 1) % 8);
      step("sat_dup", 1'b1, m_prev);
    end
    chk("sat.err_const", int'(err_cnt), 15);
    for (int k = 0; k < LOCK_N; k++) step("sat_relock2", 1'b1, (m_prev + 1) % 8);

    // enable low with a changing input holds everything
    for (int i = 0; i < 5; i++) step("hold", 1'b0, (m_prev + 3 + i) % 8);
    step("resume", 1'b1, (m_prev + 1) % 8);
    chk("resume.locked_const", int'(locked), 1);

    // build laps up to 9 while locked
    while (m_lap < 9) step("lap", 1'b1, (m_prev + 1) % 8);
    chk("lap.lap_const", int'(lap_cnt), 9);

    // asynchronous reset between edges
    enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst", rst_exp);
    #4 reset = 1'b0;

    // first sample after reset is a capture only
    step("post2", 1'b1, 2);
    chk("post2.locked_const", int'(locked), 0);
    step("post3", 1'b1, 3);
    step("post4", 1'b1, 4);
    step("post5", 1'b1, 5);
    chk("post.locked_const", int'(locked), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
